// File: rtl/mul_div_unit.sv
`default_nettype none
// ============================================================================
// mul_div_unit : iterative 32-cycle MULT/MULTU/DIV/DIVU unit with HI/LO regs
// Revision     : 1.0
// ============================================================================
module mul_div_unit #(
   parameter int DATA_LEN = 32
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [1:0]          op,
   input  logic [DATA_LEN-1:0] src_a,
   input  logic [DATA_LEN-1:0] src_b,
   input  logic                hi_we,
   input  logic                lo_we,
   input  logic [DATA_LEN-1:0] wdata,
   output logic                busy,
   output logic                done,
   output logic [DATA_LEN-1:0] hi,
   output logic [DATA_LEN-1:0] lo
);

   localparam int                CNT_W    = $clog2(DATA_LEN);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_LEN - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      CALC = 1'b1
   } state_t;

   state_t                    state_q, state_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;
   logic                      is_div_q, is_div_d;
   logic                      neg_q, neg_d;
   logic                      rem_neg_q, rem_neg_d;
   logic                      div0_q, div0_d;
   logic [DATA_LEN-1:0]       opnd_q, opnd_d;
   logic [2*DATA_LEN-1:0]     work_q, work_d;
   logic [DATA_LEN-1:0]       hi_q, hi_d;
   logic [DATA_LEN-1:0]       lo_q, lo_d;

   logic                      sgn_op;
   logic [DATA_LEN-1:0]       a_mag, b_mag;
   logic [DATA_LEN-1:0]       addend;
   logic [DATA_LEN:0]         add_sum, shifted, diff;
   logic [2*DATA_LEN-1:0]     work_nx, prod_fix;
   logic [DATA_LEN-1:0]       quo_fix, rem_fix;

   // work_q holds {partial product, multiplier} for multiply and
   // {partial remainder, dividend/quotient} for divide.
   always_comb begin
      sgn_op  = ~op[0];
      a_mag   = (sgn_op & src_a[DATA_LEN-1]) ? -src_a : src_a;
      b_mag   = (sgn_op & src_b[DATA_LEN-1]) ? -src_b : src_b;

      addend  = work_q[0] ? opnd_q : {DATA_LEN{1'b0}};
      add_sum = {1'b0, work_q[2*DATA_LEN-1:DATA_LEN]} + {1'b0, addend};
      shifted = {work_q[2*DATA_LEN-1:DATA_LEN], work_q[DATA_LEN-1]};
      diff    = shifted - {1'b0, opnd_q};

      if (is_div_q) begin
         if (diff[DATA_LEN])
            work_nx = {shifted[DATA_LEN-1:0], work_q[DATA_LEN-2:0], 1'b0};
         else
            work_nx = {diff[DATA_LEN-1:0], work_q[DATA_LEN-2:0], 1'b1};
      end else begin
         work_nx = {add_sum, work_q[DATA_LEN-1:1]};
      end

      prod_fix = neg_q ? -work_nx : work_nx;
      rem_fix  = rem_neg_q ? -work_nx[2*DATA_LEN-1:DATA_LEN]
                           :  work_nx[2*DATA_LEN-1:DATA_LEN];
      if (div0_q)
         quo_fix = {DATA_LEN{1'b1}};
      else
         quo_fix = neg_q ? -work_nx[DATA_LEN-1:0] : work_nx[DATA_LEN-1:0];
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      is_div_d  = is_div_q;
      neg_d     = neg_q;
      rem_neg_d = rem_neg_q;
      div0_d    = div0_q;
      opnd_d    = opnd_q;
      work_d    = work_q;
      hi_d      = hi_q;
      lo_d      = lo_q;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = CALC;
               busy_d    = 1'b1;
               cnt_d     = '0;
               is_div_d  = op[1];
               neg_d     = sgn_op & (src_a[DATA_LEN-1] ^ src_b[DATA_LEN-1]);
               rem_neg_d = sgn_op & op[1] & src_a[DATA_LEN-1];
               div0_d    = op[1] & (src_b == {DATA_LEN{1'b0}});
               opnd_d    = op[1] ? b_mag : a_mag;
               work_d    = {{DATA_LEN{1'b0}}, (op[1] ? a_mag : b_mag)};
            end else begin
               if (hi_we) hi_d = wdata;
               if (lo_we) lo_d = wdata;
            end
         end
         CALC: begin
            work_d = work_nx;
            cnt_d  = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               if (is_div_q) begin
                  hi_d = rem_fix;
                  lo_d = quo_fix;
               end else begin
                  hi_d = prod_fix[2*DATA_LEN-1:DATA_LEN];
                  lo_d = prod_fix[DATA_LEN-1:0];
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rem_neg_q <= 1'b0;
         div0_q    <= 1'b0;
         opnd_q    <= '0;
         work_q    <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         is_div_q  <= is_div_d;
         neg_q     <= neg_d;
         rem_neg_q <= rem_neg_d;
         div0_q    <= div0_d;
         opnd_q    <= opnd_d;
         work_q    <= work_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
`default_nettype wire
